// File: rtl/mod_counter_if.sv
// mod_counter_if: control and status bundle for mod_counter.
interface mod_counter_if #(
   parameter int WIDTH = 6
);
   logic             en;
   logic             up;
   logic             ld;
   logic [WIDTH-1:0] ld_val;
   logic [WIDTH-1:0] out;
   logic             tc;
   logic             wrap;
   modport master (output en, up, ld, ld_val, input out, tc, wrap);
   modport slave  (input en, up, ld, ld_val, output out, tc, wrap);
endinterface

// File: rtl/mod_counter.sv
// mod_counter: modulo-N up/down counter with parallel load, terminal-count and wrap flags.
// Defining CNT_PRESCALE_EN adds a prescaler so a step occurs every PRESCALE enabled cycles.
module mod_counter #(
   parameter int     WIDTH    = 6,
   parameter longint MODULUS  = 64,
   parameter int     PRESCALE = 1
) (
   input logic          clk,
   input logic          clr,
   mod_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
   logic [WIDTH-1:0] out_q, out_d;
   logic             wrap_q, wrap_d;
   logic             step, term;
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("mod_counter: WIDTH out of range");
   end
   if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_mod
      $error("mod_counter: MODULUS out of range");
   end
   if (PRESCALE < 1) begin : g_bad_pre
      $error("mod_counter: PRESCALE must be at least 1");
   end
`ifdef CNT_PRESCALE_EN
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   logic [PW-1:0] pre_q, pre_d;
   assign step = bus.en & (pre_q == PW'(PRESCALE - 1));
   always_comb pre_d = (bus.ld | step) ? '0 : bus.en ? pre_q + PW'(1) : pre_q;
   always_ff @(posedge clk) pre_q <= clr ? '0 : pre_d;
`else
   assign step = bus.en;
`endif
   // terminal condition depends on the direction presented this cycle
   assign term = bus.up ? (out_q == MAX) : (out_q == '0);
   always_comb begin
      out_d  = bus.ld  ? ((bus.ld_val > MAX) ? MAX : bus.ld_val)
             : !step   ? out_q
             : bus.up  ? (term ? '0 : out_q + WIDTH'(1))
             :           (term ? MAX : out_q - WIDTH'(1));
      wrap_d = step & term & ~bus.ld;
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         out_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         wrap_q <= wrap_d;
      end
   end
   assign bus.out  = out_q;
   assign bus.wrap = wrap_q;
   assign bus.tc   = step & term & ~clr & ~bus.ld;
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: table-driven bench with reference model and scoreboard over three counter configurations.
module tb_mod_counter;
   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;
   mod_counter_if #(6) b0 ();
   mod_counter_if #(4) b1 ();
   mod_counter_if #(4) b2 ();
   mod_counter #(.WIDTH(6), .MODULUS(64)) u0 (.clk(clk), .clr(clr), .bus(b0));
   mod_counter #(.WIDTH(4), .MODULUS(10)) u1 (.clk(clk), .clr(clr), .bus(b1));
   mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u2 (.clk(clk), .clr(clr), .bus(b2));
   typedef struct {
      bit clr, en, up, ld;
      int ldv;
      int n;
      int exp10;
   } vec_t;
   typedef struct {
      int k;
      int out;
      int wrap;
   } exp_t;
   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   m_out[3]  = '{0, 0, 0};
   int   m_wrap[3] = '{0, 0, 0};
   int   m_pre[3]  = '{0, 0, 0};
   int   md[3] = '{64, 10, 10};
   int   wd[3] = '{6, 4, 4};
`ifdef CNT_PRESCALE_EN
   int   ps[3] = '{1, 1, 3};
`else
   int   ps[3] = '{1, 1, 1};
`endif
   vec_t tbl[$];
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   function automatic int dout(input int k);
      return k == 0 ? int'(b0.out) : k == 1 ? int'(b1.out) : int'(b2.out);
   endfunction
   function automatic int dwrap(input int k);
      return k == 0 ? int'(b0.wrap) : k == 1 ? int'(b1.wrap) : int'(b2.wrap);
   endfunction
   function automatic int dtc(input int k);
      return k == 0 ? int'(b0.tc) : k == 1 ? int'(b1.tc) : int'(b2.tc);
   endfunction
   task automatic cycle(input vec_t v);
      exp_t e;
      @(negedge clk);
      clr = v.clr;
      b0.en = v.en; b0.up = v.up; b0.ld = v.ld; b0.ld_val = 6'(v.ldv);
      b1.en = v.en; b1.up = v.up; b1.ld = v.ld; b1.ld_val = 4'(v.ldv);
      b2.en = v.en; b2.up = v.up; b2.ld = v.ld; b2.ld_val = 4'(v.ldv);
      #1;
      for (int k = 0; k < 3; k++) begin
         int lv, stp, term, tce;
         lv   = v.ldv % (1 << wd[k]);
         stp  = int'(v.en && m_pre[k] == ps[k] - 1);
         term = v.up ? int'(m_out[k] == md[k] - 1) : int'(m_out[k] == 0);
         tce  = int'(!v.clr && !v.ld && stp != 0 && term != 0);
         chk($sformatf("tc[%0d]", k), dtc(k), tce);
         if (v.clr) begin
            m_out[k] = 0; m_wrap[k] = 0; m_pre[k] = 0;
         end else if (v.ld) begin
            m_out[k] = lv >= md[k] ? md[k] - 1 : lv; m_wrap[k] = 0; m_pre[k] = 0;
         end else if (stp != 0) begin
            if (v.up) m_out[k] = term != 0 ? 0 : m_out[k] + 1;
            else      m_out[k] = term != 0 ? md[k] - 1 : m_out[k] - 1;
            m_wrap[k] = term; m_pre[k] = 0;
         end else begin
            if (v.en) m_pre[k]++;
            m_wrap[k] = 0;
         end
         sb.push_back('{k, m_out[k], m_wrap[k]});
      end
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk($sformatf("out[%0d]", e.k), dout(e.k), e.out);
         chk($sformatf("wrap[%0d]", e.k), dwrap(e.k), e.wrap);
      end
   endtask
   initial begin
      b0.en = 0; b0.up = 0; b0.ld = 0; b0.ld_val = '0;
      b1.en = 0; b1.up = 0; b1.ld = 0; b1.ld_val = '0;
      b2.en = 0; b2.up = 0; b2.ld = 0; b2.ld_val = '0;
      //        clr en up ld ldv  n  exp10
      tbl.push_back('{1, 0, 0, 0, 0,  2, 0});
      tbl.push_back('{0, 1, 1, 0, 0, 64, 4});
      tbl.push_back('{1, 0, 0, 0, 0,  1, 0});
      tbl.push_back('{0, 1, 0, 0, 0,  1, 9});
      tbl.push_back('{0, 1, 0, 0, 0,  2, 7});
      tbl.push_back('{0, 1, 1, 1, 12, 1, 9});
      tbl.push_back('{0, 1, 1, 0, 0,  1, 0});
      tbl.push_back('{0, 0, 0, 1, 5,  1, 5});
      tbl.push_back('{1, 1, 1, 1, 7,  3, 0});
      tbl.push_back('{0, 1, 1, 0, 0,  1, 1});
      tbl.push_back('{0, 0, 1, 0, 0,  1, 1});
      tbl.push_back('{0, 1, 1, 0, 0,  1, 2});
      tbl.push_back('{0, 0, 0, 0, 0,  1, 2});
      tbl.push_back('{0, 0, 0, 1, 9,  1, 9});
      tbl.push_back('{0, 1, 1, 0, 0,  1, 0});
      tbl.push_back('{0, 1, 0, 0, 0,  1, 9});
      tbl.push_back('{0, 0, 0, 1, 15, 1, 9});
      tbl.push_back('{0, 0, 0, 1, 63, 1, 9});
      tbl.push_back('{0, 1, 1, 0, 0,  1, 0});
      tbl.push_back('{0, 1, 1, 0, 0,  2, 2});
      tbl.push_back('{0, 1, 0, 0, 0,  1, 1});
      tbl.push_back('{1, 0, 0, 0, 0,  1, 0});
      tbl.push_back('{0, 1, 1, 0, 0,  7, 7});
      tbl.push_back('{0, 1, 1, 0, 0,  1, 8});
      tbl.push_back('{0, 1, 1, 1, 0,  1, 0});
      tbl.push_back('{0, 1, 1, 0, 0,  2, 2});
      tbl.push_back('{0, 1, 1, 0, 0,  1, 3});
      foreach (tbl[i]) begin
         for (int r = 0; r < tbl[i].n; r++) cycle(tbl[i]);
         chk($sformatf("row%0d_mod10", i), dout(1), tbl[i].exp10);
      end
`ifdef CNT_PRESCALE_EN
      chk("prescale_phase", dout(2), 1);
`else
      chk("prescale_off", dout(2), 3);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
